// File: rtl/batalha_pkg.sv
// Shared types and constants for the battleship placement logic.
// Optional CPU auto-placement is enabled with the macro FLEET_PLACER_AUTO_CPU_EN.
package batalha_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DIR,
        ST_ORIENT,
        ST_SET_X,
        ST_SET_Y,
        ST_CHECK,
        ST_STORE,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        SUBMARINO,
        CRUZADOR,
        HIDROAVIAO,
        ENCOURACADO,
        PORTA_AVIOES
    } ship_t;

    localparam int N_SHIP_TYPES = 5;
    // Ships of each type per player, indexed by ship_t.
    localparam int FLEET_COUNT [N_SHIP_TYPES] = '{5, 2, 2, 1, 1};

    localparam logic DIR_HORIZONTAL = 1'b0;
    localparam logic DIR_VERTICAL   = 1'b1;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Bit order of the one-hot state display.
    localparam state_t LED_ORDER [6] = '{ST_DIR, ST_ORIENT, ST_SET_X, ST_SET_Y, ST_CHECK, ST_STORE};

    // Fleet count for a type; types beyond the table contribute no ships.
    function automatic int fleet_count(input int t);
        if (t >= 0 && t < N_SHIP_TYPES) begin
            return FLEET_COUNT[t];
        end
        return 0;
    endfunction

    // First type at or after 'from' that has ships; n_types when none remain.
    function automatic int next_type(input int from, input int n_types);
        int r;
        r = n_types;
        for (int t = 15; t >= 0; t--) begin
            if (t >= from && t < n_types && fleet_count(t) != 0) begin
                r = t;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/placer_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) that steps on every enabled cycle.
module placer_lfsr
    import batalha_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] value
);

    logic [15:0] lfsr_q, lfsr_d;

    // Next LFSR value: shift right, fold taps in when the output bit is set.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        end
    end

    // LFSR register, seeded on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/fleet_placer.sv
// Ship placement controller: walks each player through direction, orientation
// and X/Y for every ship, hands candidates to the validator, strobes accepted
// ships into board memory and raises ready once all fleets are placed.
// Macro FLEET_PLACER_AUTO_CPU_EN: in mode 0 the last player is placed by an LFSR.
module fleet_placer
    import batalha_pkg::*;
#(
    parameter int COORD_W    = 4,
    parameter int BOARD_SIZE = 10,
    parameter int N_TYPES    = 5,
    parameter int N_ORIENT   = 5,
    parameter int N_PLAYERS  = 2,
    localparam int TYPE_W    = $clog2(N_TYPES),
    localparam int PLAYER_W  = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                enter,
    input  logic                select,
    input  logic                mode,
    input  logic                val_done,
    input  logic                val_conflict,
    output logic                val_req,
    output logic                store_we,
    output logic [PLAYER_W-1:0] player,
    output logic [TYPE_W-1:0]   ship_type,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  y,
    output logic                direcao,
    output logic [2:0]          orientacao,
    output logic [5:0]          state_led,
    output logic                ready
);

    localparam logic [COORD_W-1:0] COORD_MAX  = COORD_W'(BOARD_SIZE - 1);
    localparam logic [2:0]         ORIENT_MAX = 3'(N_ORIENT - 1);
    localparam logic [15:0]        COORD_MOD  = 16'(BOARD_SIZE);
    localparam logic [15:0]        ORIENT_MOD = 16'(N_ORIENT);

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [2:0]            orient_q, orient_d;
    logic [COORD_W-1:0]    x_q, x_d, y_q, y_d;
    logic [PLAYER_W-1:0]   player_q, player_d;
    logic [TYPE_W-1:0]     type_q, type_d;
    logic [7:0]            count_q, count_d;
    logic                  val_req_q, val_req_d;
    logic                  store_we_q, store_we_d;
    logic [5:0]            led_q, led_d;
    logic                  ready_q, ready_d;
    logic                  auto_cpu;
    logic [15:0]           rnd;
    int                    nt;

`ifdef FLEET_PLACER_AUTO_CPU_EN
    placer_lfsr u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .value  (rnd)
    );
    assign auto_cpu = !mode && (player_q == PLAYER_W'(N_PLAYERS - 1));
`else
    assign rnd      = 16'd0;
    assign auto_cpu = 1'b0;
    wire   unused_mode = mode;
`endif

    // Next-state and field updates; enable low holds everything.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        orient_d = orient_q;
        x_d      = x_q;
        y_d      = y_q;
        player_d = player_q;
        type_d   = type_q;
        count_d  = count_q;
        nt       = 0;
        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    nt = next_type(0, N_TYPES);
                    if (nt < N_TYPES) begin
                        type_d  = TYPE_W'(nt);
                        state_d = ST_DIR;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_DIR: begin
                    if (auto_cpu) begin
                        dir_d   = rnd[0];
                        state_d = ST_ORIENT;
                    end else begin
                        if (select) dir_d = ~dir_q;
                        if (enter) state_d = ST_ORIENT;
                    end
                end
                ST_ORIENT: begin
                    if (auto_cpu) begin
                        orient_d = 3'(rnd % ORIENT_MOD);
                        state_d  = ST_SET_X;
                    end else begin
                        if (select) orient_d = (orient_q == ORIENT_MAX) ? 3'd0 : orient_q + 3'd1;
                        if (enter) state_d = ST_SET_X;
                    end
                end
                ST_SET_X: begin
                    if (auto_cpu) begin
                        x_d     = COORD_W'(rnd % COORD_MOD);
                        state_d = ST_SET_Y;
                    end else begin
                        if (select) x_d = (x_q == COORD_MAX) ? '0 : x_q + 1'b1;
                        if (enter) state_d = ST_SET_Y;
                    end
                end
                ST_SET_Y: begin
                    if (auto_cpu) begin
                        y_d     = COORD_W'(rnd % COORD_MOD);
                        state_d = ST_CHECK;
                    end else begin
                        if (select) y_d = (y_q == COORD_MAX) ? '0 : y_q + 1'b1;
                        if (enter) state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (val_done) state_d = val_conflict ? ST_SET_X : ST_STORE;
                end
                ST_STORE: begin
                    state_d = ST_DIR;
                    if (int'(count_q) + 1 >= fleet_count(int'(type_q))) begin
                        count_d = '0;
                        nt      = next_type(int'(type_q) + 1, N_TYPES);
                        if (nt < N_TYPES) begin
                            type_d = TYPE_W'(nt);
                        end else if (int'(player_q) < N_PLAYERS - 1) begin
                            player_d = player_q + 1'b1;
                            type_d   = TYPE_W'(next_type(0, N_TYPES));
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // One-hot state display decoded from the upcoming state.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_led
            assign led_d[gi] = (state_d == LED_ORDER[gi]);
        end
    endgenerate

    // Registered strobes and status derived from the upcoming state.
    always_comb begin
        val_req_d  = (state_d == ST_CHECK);
        store_we_d = (state_d == ST_STORE);
        ready_d    = ready_q | (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_HORIZONTAL;
            orient_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            player_q   <= '0;
            type_q     <= '0;
            count_q    <= '0;
            val_req_q  <= 1'b0;
            store_we_q <= 1'b0;
            led_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            orient_q   <= orient_d;
            x_q        <= x_d;
            y_q        <= y_d;
            player_q   <= player_d;
            type_q     <= type_d;
            count_q    <= count_d;
            val_req_q  <= val_req_d;
            store_we_q <= store_we_d;
            led_q      <= led_d;
            ready_q    <= ready_d;
        end
    end

    assign val_req    = val_req_q;
    assign store_we   = store_we_q;
    assign player     = player_q;
    assign ship_type  = type_q;
    assign x          = x_q;
    assign y          = y_q;
    assign direcao    = dir_q;
    assign orientacao = orient_q;
    assign state_led  = led_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_fleet_placer.sv
// Directed + randomized bench for fleet_placer against a simple placement model.
module tb_fleet_placer;

    localparam int BOARD = 10;
    localparam int NOR   = 5;
    localparam int NT    = 5;
    localparam int NPL   = 2;

    localparam int LED_DIR = 1, LED_OR = 2, LED_X = 4, LED_Y = 8, LED_CHK = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0, enter = 1'b0, select = 1'b0, mode = 1'b1;
    logic val_done = 1'b0, val_conflict = 1'b0;

    logic       val_req, store_we, direcao, ready;
    logic [0:0] player;
    logic [2:0] ship_type, orientacao;
    logic [3:0] x, y;
    logic [5:0] state_led;

    int checks = 0;
    int failures = 0;

    int ref_counts [NT] = '{5, 2, 2, 1, 1};
    int ship_player [$];
    int ship_kind [$];
    int exp_dir = 0, exp_or = 0, exp_x = 0, exp_y = 0;

    fleet_placer dut (
        .clk(clk), .reset(reset), .enable(enable), .enter(enter), .select(select),
        .mode(mode), .val_done(val_done), .val_conflict(val_conflict),
        .val_req(val_req), .store_we(store_we), .player(player), .ship_type(ship_type),
        .x(x), .y(y), .direcao(direcao), .orientacao(orientacao),
        .state_led(state_led), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_n(input int n);
        for (int i = 0; i < n; i++) begin
            select = 1'b1;
            tick();
            select = 1'b0;
        end
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
    endtask

    task automatic chk_fields(input string tag);
        chk({tag, "_dir"}, direcao, exp_dir);
        chk({tag, "_or"}, orientacao, exp_or);
        chk({tag, "_x"}, x, exp_x);
        chk({tag, "_y"}, y, exp_y);
    endtask

    // Walk DIR..SET_Y with the given select counts, ending in CHECK.
    task automatic to_check(input int dn, input int on, input int xn, input int yn);
        chk("led_dir", state_led, LED_DIR);
        sel_n(dn); exp_dir = exp_dir ^ (dn % 2);
        chk("dir", direcao, exp_dir);
        press_enter();
        chk("led_or", state_led, LED_OR);
        sel_n(on); exp_or = (exp_or + on) % NOR;
        chk("or", orientacao, exp_or);
        press_enter();
        chk("led_x", state_led, LED_X);
        sel_n(xn); exp_x = (exp_x + xn) % BOARD;
        chk("x", x, exp_x);
        press_enter();
        chk("led_y", state_led, LED_Y);
        sel_n(yn); exp_y = (exp_y + yn) % BOARD;
        chk("y", y, exp_y);
        press_enter();
        chk("led_chk", state_led, LED_CHK);
        chk("val_req", val_req, 1);
    endtask

    // Linger in CHECK with ignored buttons, then accept and check the store.
    task automatic finish_check(input int idx, input int wait_n);
        for (int i = 0; i < wait_n; i++) begin
            select = 1'b1; enter = 1'b1;
            tick();
            select = 1'b0; enter = 1'b0;
        end
        chk("chk_hold_led", state_led, LED_CHK);
        chk("chk_hold_req", val_req, 1);
        val_done = 1'b1; val_conflict = 1'b0;
        tick();
        val_done = 1'b0;
        chk("store_we", store_we, 1);
        chk("store_req", val_req, 0);
        chk("store_player", player, ship_player[idx]);
        chk("store_type", ship_type, ship_kind[idx]);
        chk_fields("store");
        $display("ship %0d: player=%0d type=%0d x=%0d y=%0d dir=%0d or=%0d", idx, player, ship_type, x, y, direcao, orientacao);
        tick();
        chk("store_end", store_we, 0);
    endtask

    task automatic place(input int idx);
        to_check($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 12));
        finish_check(idx, $urandom_range(0, 2));
    endtask

    task automatic do_reset_release();
        exp_dir = 0; exp_or = 0; exp_x = 0; exp_y = 0;
        tick();
        reset = 1'b1;
        tick();
        chk("rel_led_dir", state_led, LED_DIR);
        chk("rel_ready", ready, 0);
        chk_fields("rel");
    endtask

    initial begin
        for (int p = 0; p < NPL; p++)
            for (int t = 0; t < NT; t++)
                for (int c = 0; c < ref_counts[t]; c++) begin
                    ship_player.push_back(p);
                    ship_kind.push_back(t);
                end

        #2 reset = 1'b0;
        #10;
        chk("rst_val_req", val_req, 0);
        chk("rst_store_we", store_we, 0);
        chk("rst_led", state_led, 0);
        chk("rst_ready", ready, 0);
        chk("rst_player", player, 0);
        chk("rst_type", ship_type, 0);
        chk_fields("rst");
        tick();
        reset = 1'b1;
        tick(); tick();
        chk("idle_led", state_led, 0);
        enable = 1'b1;
        tick();
        chk("first_dir", state_led, LED_DIR);

        // Ship 0: dir 1, orientation 2, x 3, y 4.
        to_check(1, 2, 3, 4);
        finish_check(0, 0);

        // Ship 1: wraps, then a conflict back to SET_X, then a clean retry.
        to_check(0, 6, 11, 0);
        chk("orient_wrap", orientacao, 3);
        chk("x_wrap", x, 4);
        val_done = 1'b1; val_conflict = 1'b1;
        tick();
        val_conflict = 1'b0;
        chk("conf_led", state_led, LED_X);
        chk("conf_we", store_we, 0);
        chk_fields("conf");
        tick();
        val_done = 1'b0;
        chk("done_outside", state_led, LED_X);
        press_enter();
        press_enter();
        chk("retry_chk", state_led, LED_CHK);
        finish_check(1, 1);

        // Ship 2: enable low in SET_Y and in CHECK.
        press_enter(); press_enter(); press_enter();
        chk("en_led_y", state_led, LED_Y);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            select = 1'b1; enter = 1'b1;
            tick();
            select = 1'b0; enter = 1'b0;
        end
        chk("en_y_hold", y, exp_y);
        chk("en_led_hold", state_led, LED_Y);
        enable = 1'b1;
        sel_n(2); exp_y = (exp_y + 2) % BOARD;
        chk("en_y_sel", y, exp_y);
        press_enter();
        enable = 1'b0;
        val_done = 1'b1;
        tick(); tick();
        val_done = 1'b0;
        chk("en_chk_led", state_led, LED_CHK);
        chk("en_chk_req", val_req, 1);
        chk("en_chk_we", store_we, 0);
        enable = 1'b1;
        finish_check(2, 0);

        for (int k = 3; k < ship_player.size(); k++) begin
            place(k);
            if (k == 10) begin
                chk("p1_player", player, 1);
                chk("p1_type", ship_type, 0);
            end
        end
        chk("ready", ready, 1);
        chk("done_led", state_led, 0);
        for (int i = 0; i < 4; i++) begin
            select = 1'b1; enter = 1'b1; val_done = 1'b1;
            tick();
        end
        select = 1'b0; enter = 1'b0; val_done = 1'b0;
        chk("ready_sticky", ready, 1);
        chk("done_x", x, exp_x);

        // Reset asserted mid-CHECK.
        reset = 1'b0;
        do_reset_release();
        to_check(0, 0, 1, 1);
        #2 reset = 1'b0;
        #1;
        chk("async_req", val_req, 0);
        chk("async_led", state_led, 0);
        chk("async_x", x, 0);
        chk("async_ready", ready, 0);
        val_done = 1'b1;
        tick();
        val_done = 1'b0;
        chk("async_we", store_we, 0);

`ifdef FLEET_PLACER_AUTO_CPU_EN
        begin
            int stores;
            mode = 1'b0;
            do_reset_release();
            for (int k = 0; k < 11; k++) place(k);
            stores = 0;
            for (int c = 0; c < 3000 && !ready; c++) begin
                tick();
                if (store_we) begin
                    stores++;
                    chk("cpu_x_range", x < BOARD, 1);
                    chk("cpu_y_range", y < BOARD, 1);
                    chk("cpu_player", player, 1);
                    $display("cpu ship %0d: type=%0d x=%0d y=%0d", stores, ship_type, x, y);
                end
                val_conflict = ($urandom_range(0, 3) == 0);
                val_done = val_req && !val_done;
            end
            val_done = 1'b0;
            chk("cpu_stores", stores, 11);
            chk("cpu_ready", ready, 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fleet_placer.md
# fleet_placer

Parametrised ship-placement controller for the battleship game, sitting between the button debouncers and the board validator/memory. Steps each player through direction, orientation and X/Y selection for every ship in a configurable fleet. Hands each candidate to the validator through a request/done handshake and writes accepted ships to the per-player board memory. Raises `ready` to start the game once all players' fleets are stored.

## Interface
Parameters:
- `COORD_W`, 4: width of X/Y coordinates.
- `BOARD_SIZE`, 10: legal coordinates 0..BOARD_SIZE-1; must be ≤ 2**COORD_W.
- `N_TYPES`, 5: number of ship types; type index width `TYPE_W = $clog2(N_TYPES)`.
- `N_ORIENT`, 5: orientation choices 0..N_ORIENT-1.
- `N_PLAYERS`, 2: players placing fleets in sequence; player index width `$clog2(N_PLAYERS)`, minimum 1.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-low.
- `enable`, in, 1: synchronous run enable. Low freezes all state; outputs hold.
- `enter`, in, 1: single-cycle pulse, already debounced and synchronised. Advances the FSM.
- `select`, in, 1: single-cycle pulse. Increments the field owned by the current state.
- `mode`, in, 1: 0 = player vs CPU, 1 = player vs player.
- `val_done`, in, 1: validator finished.
- `val_conflict`, in, 1: sampled when `val_done` is high; 1 = overlap or out of board.
- `val_req`, out, 1: candidate valid, held until `val_done`.
- `store_we`, out, 1: one-cycle write strobe to board memory.
- `player`, out, player width: player whose fleet is being placed.
- `ship_type`, out, TYPE_W: current ship type.
- `x`, `y`, out, COORD_W: candidate origin.
- `direcao`, out, 1: 0 = horizontal, 1 = vertical.
- `orientacao`, out, 3: orientation index.
- `state_led`, out, 6: one-hot display of DIR/ORIENT/SET_X/SET_Y/CHECK/STORE. All zero in IDLE and DONE.
- `ready`, out, 1: all fleets placed. Sticky until reset.

## Operation
- Reset values: all outputs 0; FSM in IDLE; type 0, per-type count 0, player 0.
- IDLE → DIR on the first cycle with `enable` high.
- State sequence is DIR → ORIENT → SET_X → SET_Y → CHECK. Each of the first four steps advances on `enter`.
- `select` actions by state:
  - DIR: toggles `direcao`.
  - ORIENT: increments `orientacao`, wrapping N_ORIENT-1 → 0.
  - SET_X: increments `x`, wrapping BOARD_SIZE-1 → 0.
  - SET_Y: increments `y`, wrapping BOARD_SIZE-1 → 0.
  - Ignored in all other states.
- CHECK:
  - `val_req` is 1 for the whole state; `enter` and `select` are ignored.
  - On `val_done` with `val_conflict` = 1: go to SET_X. `x`, `y`, `direcao` and `orientacao` are retained.
  - On `val_done` with `val_conflict` = 0: go to STORE.
- STORE lasts exactly one cycle with `store_we` = 1, then the per-type count increments.
  - If count equals `FLEET_COUNT[ship_type]`: the count clears and the type increments.
  - After the last type: if `player` < N_PLAYERS-1, player increments, type and count clear, and the FSM returns to DIR. Otherwise go to DONE.
- DONE: `ready` = 1. All inputs ignored until reset.
- A type whose `FLEET_COUNT` is 0 is skipped with no STORE.
- `x`, `y`, `direcao` and `orientacao` are not cleared between ships.
- `enter` and `select` in the same cycle: `select` applies to the current state's field, then `enter` advances.

## Timing
- All state changes happen on `clk` rising edge. Outputs are registered.
- `val_req` rises the cycle after the `enter` that leaves SET_Y.
- `store_we` is high the cycle after `val_done`.
- `val_done` arriving the same cycle `val_req` rises is accepted.
- A `val_done` seen outside CHECK is ignored.
- Asynchronous reset mid-CHECK or mid-STORE drops `val_req` and `store_we` immediately. No partial write is allowed.
- `enable` low during CHECK holds `val_req` high and the FSM stays in CHECK. A `val_done` arriving while `enable` is low is lost, so the validator must hold it until it sees `enable` high.

## Configuration
- `FLEET_PLACER_AUTO_CPU_EN` defined:
  - When `mode` = 0, player N_PLAYERS-1 is the CPU.
  - For the CPU, DIR/ORIENT/SET_X/SET_Y advance automatically, one per cycle, with fields taken from a 16-bit LFSR.
  - The LFSR seed is 16'hACE1. It is reduced modulo BOARD_SIZE and N_ORIENT.
  - A conflict redraws a new candidate; `enter` and `select` are ignored.
- `FLEET_PLACER_AUTO_CPU_EN` undefined:
  - `mode` is ignored and every player places manually.
  - No LFSR is synthesised.

## Structure
- Shared package `batalha_pkg` holds:
  - the state enum;
  - the ship type enum (SUBMARINO, CRUZADOR, HIDROAVIAO, ENCOURACADO, PORTA_AVIOES);
  - `FLEET_COUNT` constant array, default {5,2,2,1,1};
  - the direction constants.
- One sub-module, `placer_lfsr`: the 16-bit Galois LFSR with enable, instantiated only under the macro.

## Test plan
- Reset, then place one submarine with direction 1, orientation 2, x=3, y=4, and `val_done`/`val_conflict`=0 → one `store_we` pulse with player 0, type 0, x=3, y=4, `direcao`=1, `orientacao`=2.
- Press `select` 11 times in SET_X with BOARD_SIZE=10 → x=1. Press `select` 6 times in ORIENT → `orientacao`=1.
- Drive `val_conflict`=1 in CHECK → FSM in SET_X with x and y unchanged, no `store_we`; a second attempt without conflict stores.
- Place 11 conflict-free ships → type sequence 0×5, 1×2, 2×2, 3×1, 4×1, then player=1 and type=0. After 22 ships, `ready`=1 and stays high.
- Assert reset during CHECK → `val_req` drops asynchronously and all outputs return to 0. Pulse `enable` low mid-SET_Y → `select` has no effect.
- With the macro defined and `mode`=0 → player 1's 11 ships are stored with no button input, every x and y < 10, and then `ready`=1.
